escaner_teclado: RTL

ESCANER_TECLADO -- requirements
Module: escaner_teclado

---
 rtl/escaner_teclado.sv | 95 +++++++++
 1 files changed

// File: rtl/escaner_teclado.sv
// 4x4 keypad scanner: drives one row low at a time, samples synchronized columns
// once per SCAN_DIV cycles, latches the first key found and holds it until release.
module escaner_teclado #(
  parameter int unsigned SCAN_DIV        = 12000,
  parameter int unsigned RELEASE_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic       tecla_presionada,
  output logic [3:0] codigo_tecla
);

  typedef enum logic {SCAN, HOLD} state_t;

  state_t      state;
  logic [3:0]  col_m;
  logic [3:0]  col_s;
  logic [15:0] div;
  logic [1:0]  row_idx;
  logic [3:0]  rel_cnt;
  logic        sample;
  logic        any_low;
  logic [1:0]  low_col;
  logic [1:0]  row_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= columnas;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         div <= '0;
    else if (sample) div <= '0;
    else             div <= div + 16'd1;
  end

  assign sample   = (div == 16'(SCAN_DIV - 1));
  assign any_low  = (col_s != 4'b1111);
  assign row_next = row_idx + 2'd1;

  // Lowest-index low column has priority when several are closed.
  always_comb begin
    low_col = 2'd3;
    if      (!col_s[0]) low_col = 2'd0;
    else if (!col_s[1]) low_col = 2'd1;
    else if (!col_s[2]) low_col = 2'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= SCAN;
      row_idx          <= 2'd0;
      filas            <= 4'b1110;
      rel_cnt          <= '0;
      tecla_presionada <= 1'b0;
      codigo_tecla     <= 4'h0;
    end else if (sample) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            codigo_tecla     <= {row_idx, low_col};
            tecla_presionada <= 1'b1;
            rel_cnt          <= '0;
            state            <= HOLD;
          end else begin
            row_idx <= row_next;
            filas   <= ~(4'b0001 << row_next);
          end
        end
        HOLD: begin
          if (any_low) begin
            rel_cnt <= '0;
          end else if (rel_cnt == 4'(RELEASE_SAMPLES - 1)) begin
            rel_cnt          <= '0;
            tecla_presionada <= 1'b0;
            row_idx          <= row_next;
            filas            <= ~(4'b0001 << row_next);
            state            <= SCAN;
          end else begin
            rel_cnt <= rel_cnt + 4'd1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule
